// File: rtl/key_debounce_pkg.sv
// Shared constants for key inputs: pin polarity codes and the default
// debounce / long-press timing for the board clock.
package key_debounce_pkg;

   localparam int unsigned KEY_ACTIVE_LOW  = 1;
   localparam int unsigned KEY_ACTIVE_HIGH = 0;

   localparam int unsigned KEY_SAMPLE_TIME_DEFAULT = 5000;
   localparam int unsigned KEY_LONG_TIME_DEFAULT   = 2000000;

endpackage

// File: rtl/key_debounce_channel.sv
// One key: polarity normalisation, 2-flop synchroniser, stability counter,
// accepted level with press/release pulses, and a saturating long-press counter.
module key_debounce_channel
   import key_debounce_pkg::*;
#(
   parameter int unsigned SAMPLE_TIME = KEY_SAMPLE_TIME_DEFAULT,
   parameter int unsigned LONG_TIME   = KEY_LONG_TIME_DEFAULT,
   parameter int unsigned ACTIVE_LOW  = KEY_ACTIVE_LOW
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic held_long_o
);

   localparam int unsigned DEB_W  = $clog2(SAMPLE_TIME + 1);
   localparam int unsigned HOLD_W = $clog2(LONG_TIME + 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(SAMPLE_TIME - 1);
   localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TIME - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TIME);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic              POL       = (ACTIVE_LOW != 0);

   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic              stable_q, stable_d;
   logic              press_q, press_d;
   logic              rel_q, rel_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              long_q, long_d;
   logic              held_long_q, held_long_d;

   always_comb begin
      sync1_d     = key_i ^ POL;
      sync2_d     = sync1_q;
      deb_cnt_d   = deb_cnt_q;
      stable_d    = stable_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      long_d      = 1'b0;
      held_long_d = held_long_q;

      // Any sample matching the accepted level throws away the running count.
      if (sync2_q == stable_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DEB_LAST) begin
         deb_cnt_d = '0;
         stable_d  = sync2_q;
         press_d   = sync2_q;
         rel_d     = ~sync2_q;
      end else begin
         deb_cnt_d = deb_cnt_q + DEB_ONE;
      end

      // A release on the threshold cycle takes priority over the long pulse.
      if (press_d) begin
         hold_cnt_d = '0;
      end else if (rel_d) begin
         hold_cnt_d  = '0;
         held_long_d = 1'b0;
      end else if (stable_q && (hold_cnt_q != HOLD_MAX)) begin
         hold_cnt_d = hold_cnt_q + HOLD_ONE;
         if (hold_cnt_q == HOLD_LAST) begin
            long_d      = 1'b1;
            held_long_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         deb_cnt_q   <= '0;
         stable_q    <= 1'b0;
         press_q     <= 1'b0;
         rel_q       <= 1'b0;
         hold_cnt_q  <= '0;
         long_q      <= 1'b0;
         held_long_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_cnt_q   <= deb_cnt_d;
         stable_q    <= stable_d;
         press_q     <= press_d;
         rel_q       <= rel_d;
         hold_cnt_q  <= hold_cnt_d;
         long_q      <= long_d;
         held_long_q <= held_long_d;
      end
   end

   assign level_o     = stable_q;
   assign press_o     = press_q;
   assign release_o   = rel_q;
   assign long_o      = long_q;
   assign held_long_o = held_long_q;

endmodule

// File: rtl/key_debounce_array.sv
// Multi-channel push-button debouncer: one independent key_debounce_channel
// per pin, all outputs reported as pressed = 1 regardless of pin polarity.
module key_debounce_array
   import key_debounce_pkg::*;
#(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned SAMPLE_TIME = KEY_SAMPLE_TIME_DEFAULT,
   parameter int unsigned LONG_TIME   = KEY_LONG_TIME_DEFAULT,
   parameter int unsigned ACTIVE_LOW  = KEY_ACTIVE_LOW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] key_in,
   output logic [CHANNELS-1:0] key_level,
   output logic [CHANNELS-1:0] key_press,
   output logic [CHANNELS-1:0] key_release,
   output logic [CHANNELS-1:0] key_long,
   output logic [CHANNELS-1:0] key_held_long
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      key_debounce_channel #(
         .SAMPLE_TIME (SAMPLE_TIME),
         .LONG_TIME   (LONG_TIME),
         .ACTIVE_LOW  (ACTIVE_LOW)
      ) u_ch (
         .clk_i       (clk),
         .rst_i       (rst),
         .key_i       (key_in[g]),
         .level_o     (key_level[g]),
         .press_o     (key_press[g]),
         .release_o   (key_release[g]),
         .long_o      (key_long[g]),
         .held_long_o (key_held_long[g])
      );
   end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array with 2 active-low keys, SAMPLE_TIME=4, LONG_TIME=10:
// directed cycle table, a sliding-window reference model under random pins, and a timed re-press.
module tb_key_debounce_array;

   localparam int NCH = 2;
   localparam int ST  = 4;
   localparam int LT  = 10;

   logic           clk = 1'b0;
   logic           rst;
   logic [NCH-1:0] key_in;
   logic [NCH-1:0] key_level, key_press, key_release, key_long, key_held_long;

   key_debounce_array #(
      .CHANNELS    (NCH),
      .SAMPLE_TIME (ST),
      .LONG_TIME   (LT),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .key_in        (key_in),
      .key_level     (key_level),
      .key_press     (key_press),
      .key_release   (key_release),
      .key_long      (key_long),
      .key_held_long (key_held_long)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, got, exp);
      end
   endtask

   function automatic logic [9:0] dut_vec();
      return {key_level, key_press, key_release, key_long, key_held_long};
   endfunction

   // Reference model: a key flips its accepted level once the last ST
   // synchronised samples (pin values from 2..ST+1 edges ago) all disagree with it.
   bit             hist[NCH][$];
   logic [NCH-1:0] m_level, m_press, m_rel, m_long, m_held;
   int             since[NCH];
   bit             pin_now;
   bit             all_diff;

   initial begin
      for (int c = 0; c < NCH; c++) begin
         for (int i = 0; i < ST + 2; i++) hist[c].push_back(1'b0);
         since[c] = -1;
      end
      m_level = '0; m_press = '0; m_rel = '0; m_long = '0; m_held = '0;
   end

   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         m_press[c] = 1'b0;
         m_rel[c]   = 1'b0;
         m_long[c]  = 1'b0;
         if (rst) begin
            hist[c].delete();
            for (int i = 0; i < ST + 2; i++) hist[c].push_back(1'b0);
            m_level[c] = 1'b0;
            m_held[c]  = 1'b0;
            since[c]   = -1;
         end else begin
            pin_now = ~key_in[c];
            hist[c].push_front(pin_now);
            while (hist[c].size() > ST + 2) void'(hist[c].pop_back());
            all_diff = 1'b1;
            for (int i = 2; i < ST + 2; i++)
               if (hist[c][i] == m_level[c]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[c] = ~m_level[c];
               if (m_level[c]) begin
                  m_press[c] = 1'b1;
                  since[c]   = 0;
               end else begin
                  m_rel[c]  = 1'b1;
                  m_held[c] = 1'b0;
                  since[c]  = -1;
               end
            end else if (m_level[c] && since[c] >= 0) begin
               since[c]++;
               if (since[c] == LT) begin
                  m_long[c] = 1'b1;
                  m_held[c] = 1'b1;
               end
            end
         end
      end
   end

   typedef struct {
      bit             rst;
      logic [NCH-1:0] key;
      logic [9:0]     exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input logic [1:0] k, input logic [1:0] lvl, input logic [1:0] prs,
                      input logic [1:0] rel, input logic [1:0] lng, input logic [1:0] hld, input int n);
      for (int i = 0; i < n; i++) tbl.push_back('{r, k, {lvl, prs, rel, lng, hld}});
   endtask

   int dwell[NCH];
   int cyc;

   initial begin
      rst    = 1'b1;
      key_in = 2'b11;

      // reset and idle
      add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 20);
      // clean press on key 0, held into long press, then released
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 9);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1);
      add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 5);
      add(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // short press of 8 cycles: no long pulse
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // bounce with 2-cycle dwell, then settle pressed
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // both keys together, reset while held, re-detected afterwards
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 1);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         rst    = tbl[i].rst;
         key_in = tbl[i].key;
         @(posedge clk);
         @(negedge clk);
         check("table", i, 32'(dut_vec()), 32'(tbl[i].exp));
      end

      // random pins with dwell times long enough to be accepted or to reach long press
      for (int c = 0; c < NCH; c++) dwell[c] = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if (dwell[c] == 0) begin
               key_in[c] = 1'($urandom_range(0, 1));
               dwell[c]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 30))
                                                        : int'($urandom_range(1, 6));
            end else begin
               dwell[c]--;
            end
         end
         rst = ($urandom_range(0, 399) == 0);
         @(posedge clk);
         @(negedge clk);
         check("random", n, 32'(dut_vec()), 32'({m_level, m_press, m_rel, m_long, m_held}));
      end

      // timed re-press of key 1 after a reset, bounded wait
      rst    = 1'b1;
      key_in = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst    = 1'b0;
      key_in = 2'b01;
      for (cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         if (key_press[1]) break;
      end
      check("press1_latency", 0, 32'(cyc), 32'(ST + 2));
      check("press1_vector", 0, 32'(key_press), 32'(2'b10));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
